qmfir_uart_host: RTL and testbench

//  Host-side initiator for the QMFIR UART register/memory protocol, placed on the test-controller side of the serial link.

---
 rtl/qmfir_uart_host_if.sv | 24 ++
 rtl/qmfir_uart_host.sv | 193 +++++++++++++++++++
 tb/tb_qmfir_uart_host.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qmfir_uart_host_if.sv
// Request/response bus of the QMFIR UART host: a test controller (master)
// issues register/memory requests and receives one response per request.
interface qmfir_uart_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_mem;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [23:0] rsp_rdata;
    logic        rsp_timeout;
    logic        pad_err;

    modport master (
        output req_valid, req_write, req_mem, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, pad_err
    );

    modport slave (
        input  req_valid, req_write, req_mem, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout, pad_err
    );
endinterface

// File: rtl/qmfir_uart_host.sv
// Host-side initiator for the QMFIR UART protocol: serialises one request into
// command/data bytes for the UART TX FIFO and gathers the 4-byte read reply.
module qmfir_uart_host #(
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    qmfir_uart_host_if.slave      host,
    output logic [7:0]            tx_din,
    output logic                  tx_we,
    input  logic                  tx_full,
    input  logic [7:0]            rx_dout,
    output logic                  rx_re,
    input  logic                  rx_empty,
    output logic [7:0]            stray_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_HI,
        ST_CMD_LO,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t                state_reg,       state_next;
    logic [15:0]           cmd_reg,         cmd_next;
    logic [31:0]           wdata_reg,       wdata_next;
    logic                  write_reg,       write_next;
    logic [1:0]            cnt_reg,         cnt_next;
    logic [TIMEOUT_W-1:0]  timer_reg,       timer_next;
    logic [15:0]           shift_reg,       shift_next;
    logic                  pad_work_reg,    pad_work_next;
    logic [23:0]           rsp_rdata_reg,   rsp_rdata_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;
    logic                  pad_err_reg,     pad_err_next;
    logic [7:0]            stray_reg,       stray_next;
    logic                  req_ready_c;
    logic                  rsp_valid_c;

    // Write-data bytes in transmission order, most significant first.
    logic [7:0] wbyte [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
        assign wbyte[gi] = wdata_reg[31 - 8*gi -: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cmd_reg         <= '0;
            wdata_reg       <= '0;
            write_reg       <= 1'b0;
            cnt_reg         <= '0;
            timer_reg       <= '0;
            shift_reg       <= '0;
            pad_work_reg    <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_timeout_reg <= 1'b0;
            pad_err_reg     <= 1'b0;
            stray_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            cmd_reg         <= cmd_next;
            wdata_reg       <= wdata_next;
            write_reg       <= write_next;
            cnt_reg         <= cnt_next;
            timer_reg       <= timer_next;
            shift_reg       <= shift_next;
            pad_work_reg    <= pad_work_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_timeout_reg <= rsp_timeout_next;
            pad_err_reg     <= pad_err_next;
            stray_reg       <= stray_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cmd_next         = cmd_reg;
        wdata_next       = wdata_reg;
        write_next       = write_reg;
        cnt_next         = cnt_reg;
        timer_next       = '0;
        shift_next       = shift_reg;
        pad_work_next    = pad_work_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_timeout_next = rsp_timeout_reg;
        pad_err_next     = pad_err_reg;
        stray_next       = stray_reg;
        tx_din           = '0;
        tx_we            = 1'b0;
        rx_re            = 1'b0;
        req_ready_c      = 1'b0;
        rsp_valid_c      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                // Anything arriving outside a read is unsolicited; drain and count it.
                rx_re = ~rx_empty;
                if (rx_re && stray_reg != 8'hFF) begin
                    stray_next = stray_reg + 8'd1;
                end
                if (host.req_valid) begin
                    cmd_next      = {host.req_write, host.req_mem, host.req_addr};
                    wdata_next    = host.req_wdata;
                    write_next    = host.req_write;
                    cnt_next      = '0;
                    pad_work_next = 1'b0;
                    state_next    = ST_CMD_HI;
                end
            end

            ST_CMD_HI: begin
                tx_din = cmd_reg[15:8];
                tx_we  = ~tx_full;
                if (tx_we) begin
                    state_next = ST_CMD_LO;
                end
            end

            ST_CMD_LO: begin
                tx_din = cmd_reg[7:0];
                tx_we  = ~tx_full;
                if (tx_we) begin
                    cnt_next   = '0;
                    state_next = write_reg ? ST_WDATA : ST_RDATA;
                end
            end

            ST_WDATA: begin
                tx_din = wbyte[cnt_reg];
                tx_we  = ~tx_full;
                if (tx_we) begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        rsp_rdata_next   = '0;
                        rsp_timeout_next = 1'b0;
                        pad_err_next     = 1'b0;
                        state_next       = ST_DONE;
                    end
                end
            end

            ST_RDATA: begin
                rx_re = ~rx_empty;
                if (rx_re) begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd0) begin
                        pad_work_next = (rx_dout != 8'h00);
                    end else begin
                        shift_next = {shift_reg[7:0], rx_dout};
                    end
                    if (cnt_reg == 2'd3) begin
                        rsp_rdata_next   = {shift_reg, rx_dout};
                        rsp_timeout_next = 1'b0;
                        pad_err_next     = pad_work_reg;
                        state_next       = ST_DONE;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    // Reply stalled too long: give up, the tail drains as stray bytes.
                    rsp_rdata_next   = '0;
                    rsp_timeout_next = 1'b1;
                    pad_err_next     = pad_work_reg;
                    state_next       = ST_DONE;
                end else begin
                    timer_next = timer_reg + TIMEOUT_W'(1);
                end
            end

            ST_DONE: begin
                rsp_valid_c = 1'b1;
                state_next  = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign host.req_ready   = req_ready_c;
    assign host.rsp_valid   = rsp_valid_c;
    assign host.rsp_rdata   = rsp_rdata_reg;
    assign host.rsp_timeout = rsp_timeout_reg;
    assign host.pad_err     = pad_err_reg;
    assign stray_cnt        = stray_reg;

endmodule

// File: tb/tb_qmfir_uart_host.sv
// Directed bench for qmfir_uart_host with byte-FIFO models on both UART sides.
module tb_qmfir_uart_host;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_din;
    logic       tx_we;
    logic       tx_full;
    logic [7:0] rx_dout;
    logic       rx_re;
    logic       rx_empty;
    logic [7:0] stray_cnt;

    always #5 clk = ~clk;

    qmfir_uart_host_if hbus ();

    qmfir_uart_host #(
        .TIMEOUT_W (16),
        .TIMEOUT   (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (hbus),
        .tx_din    (tx_din),
        .tx_we     (tx_we),
        .tx_full   (tx_full),
        .rx_dout   (rx_dout),
        .rx_re     (rx_re),
        .rx_empty  (rx_empty),
        .stray_cnt (stray_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_mem [0:255];
    int         rx_wr = 0;
    int         rx_rd = 0;
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_dout  = rx_mem[rx_rd[7:0]];

    logic [7:0] tx_log [0:511];
    int         tx_n = 0;
    int         viol = 0;
    int         dbl = 0;
    int         rsp_cnt = 0;
    int         rsp_cyc = 0;
    int         last_pop_cyc = 0;
    logic       prev_rsp = 1'b0;
    logic [23:0] rsp_data_q = '0;
    logic        rsp_to_q = 1'b0;
    logic        rsp_pad_q = 1'b0;
    bit          bp_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_re && !rx_empty) rx_rd <= rx_rd + 1;
    end

    always @(negedge clk) begin
        if (tx_we && tx_full) viol++;
        if (rx_re && rx_empty) viol++;
        if (tx_we && !tx_full) begin
            tx_log[tx_n[8:0]] = tx_din;
            tx_n++;
        end
        if (rx_re && !rx_empty) last_pop_cyc = cyc + 1;
        if (hbus.rsp_valid) begin
            if (prev_rsp) dbl++;
            rsp_cnt++;
            rsp_cyc    = cyc;
            rsp_data_q = hbus.rsp_rdata;
            rsp_to_q   = hbus.rsp_timeout;
            rsp_pad_q  = hbus.pad_err;
        end
        prev_rsp = hbus.rsp_valid;
    end

    initial begin
        tx_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr[7:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic do_req(input bit w, input bit m, input logic [13:0] a,
                          input logic [31:0] d, output int acc);
        hbus.req_write = w;
        hbus.req_mem   = m;
        hbus.req_addr  = a;
        hbus.req_wdata = d;
        hbus.req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hbus.req_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        hbus.req_valid = 1'b0;
        chk_val("accept", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_rsp(input int n0, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (rsp_cnt > n0) break;
        end
        chk_val("rsp_seen", 32'(rsp_cnt > n0), 32'd1);
        $display("txn %0d rdata=%06h timeout=%0b pad_err=%0b tx_bytes=%0d",
                 rsp_cnt, rsp_data_q, rsp_to_q, rsp_pad_q, tx_n);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tx(input string tag, input int n0, input int n, input logic [47:0] exp);
        chk_val({tag, "_count"}, 32'(tx_n - n0), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk_val($sformatf("%s_b%0d", tag, i), 32'(tx_log[(n0 + i) % 512]),
                    32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    int acc;
    int n0;
    int r0;
    int lat;

    initial begin
        rst = 1'b1;
        hbus.req_valid = 1'b0;
        hbus.req_write = 1'b0;
        hbus.req_mem   = 1'b0;
        hbus.req_addr  = '0;
        hbus.req_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_val("rst_req_ready", 32'(hbus.req_ready), 32'd1);
        chk_val("rst_tx_we", 32'(tx_we), 32'd0);
        chk_val("rst_rx_re", 32'(rx_re), 32'd0);
        chk_val("rst_rsp_valid", 32'(hbus.rsp_valid), 32'd0);
        chk_val("rst_rdata", 32'(hbus.rsp_rdata), 32'd0);
        chk_val("rst_timeout", 32'(hbus.rsp_timeout), 32'd0);
        chk_val("rst_pad_err", 32'(hbus.pad_err), 32'd0);
        chk_val("rst_stray", 32'(stray_cnt), 32'd0);
        tick();

        // Register write
        n0 = tx_n; r0 = rsp_cnt;
        do_req(1'b1, 1'b0, 14'h0012, 32'hA1B2C3D4, acc);
        wait_rsp(r0, 100);
        expect_tx("wr", n0, 6, 48'h8012_A1B2_C3D4);
        chk_val("wr_rdata", 32'(rsp_data_q), 32'd0);
        chk_val("wr_timeout", 32'(rsp_to_q), 32'd0);
        lat = rsp_cyc - (acc - 1);
        chk_val("wr_latency_ge7", 32'(lat >= 7), 32'd1);

        // Memory read with an immediate reply
        n0 = tx_n; r0 = rsp_cnt;
        do_req(1'b0, 1'b1, 14'h3FFF, 32'hFFFF_FFFF, acc);
        push_rx(8'h00); push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
        wait_rsp(r0, 100);
        expect_tx("rd", n0, 2, 48'h7FFF);
        chk_val("rd_rdata", 32'(rsp_data_q), 32'h112233);
        chk_val("rd_timeout", 32'(rsp_to_q), 32'd0);
        chk_val("rd_pad_err", 32'(rsp_pad_q), 32'd0);
        lat = rsp_cyc - (acc - 1);
        chk_val("rd_latency_ge7", 32'(lat >= 7), 32'd1);

        // Unsolicited bytes while idle
        push_rx(8'hE1); push_rx(8'hE2); push_rx(8'hE3);
        repeat (6) tick();
        chk_val("stray_3", 32'(stray_cnt), 32'd3);

        // Read timeout after two reply bytes, late tail counted as stray
        n0 = tx_n; r0 = rsp_cnt;
        do_req(1'b0, 1'b0, 14'h0003, 32'd0, acc);
        push_rx(8'h00); push_rx(8'hAB);
        wait_rsp(r0, 400);
        expect_tx("to", n0, 2, 48'h0003);
        chk_val("to_flag", 32'(rsp_to_q), 32'd1);
        chk_val("to_rdata", 32'(rsp_data_q), 32'd0);
        chk_val("to_delay", 32'(rsp_cyc - last_pop_cyc), 32'd100);
        push_rx(8'hCD); push_rx(8'hEF);
        repeat (5) tick();
        chk_val("stray_late", 32'(stray_cnt), 32'd5);
        chk_val("to_hold", 32'(hbus.rsp_timeout), 32'd1);

        // Bad pad byte
        n0 = tx_n; r0 = rsp_cnt;
        do_req(1'b0, 1'b0, 14'h0100, 32'd0, acc);
        push_rx(8'h5A); push_rx(8'h01); push_rx(8'h02); push_rx(8'h03);
        wait_rsp(r0, 100);
        expect_tx("pad", n0, 2, 48'h0100);
        chk_val("pad_flag", 32'(rsp_pad_q), 32'd1);
        chk_val("pad_rdata", 32'(rsp_data_q), 32'h010203);
        chk_val("pad_timeout", 32'(rsp_to_q), 32'd0);
        repeat (4) tick();
        chk_val("pad_hold", 32'(hbus.pad_err), 32'd1);

        // Memory write under random TX backpressure
        n0 = tx_n; r0 = rsp_cnt;
        bp_en = 1'b1;
        do_req(1'b1, 1'b1, 14'h0155, 32'h0F1E2D3C, acc);
        wait_rsp(r0, 300);
        bp_en = 1'b0;
        tick();
        expect_tx("bp", n0, 6, 48'hC155_0F1E_2D3C);
        chk_val("bp_rdata", 32'(rsp_data_q), 32'd0);
        chk_val("bp_pad_err", 32'(rsp_pad_q), 32'd0);

        // Stray counter saturation
        for (int i = 0; i < 260; i++) begin
            push_rx(8'(i));
            tick();
        end
        repeat (5) tick();
        chk_val("stray_sat", 32'(stray_cnt), 32'd255);

        // Reset in the middle of a write
        n0 = tx_n; r0 = rsp_cnt;
        do_req(1'b1, 1'b0, 14'h0777, 32'h12345678, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_n - n0 >= 3) break;
        end
        chk_val("mid_3rd_byte", 32'(tx_n - n0 >= 3), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_val("mid_req_ready", 32'(hbus.req_ready), 32'd1);
        chk_val("mid_stray", 32'(stray_cnt), 32'd0);
        tick();
        repeat (20) tick();
        chk_val("mid_no_rsp", 32'(rsp_cnt), 32'(r0));

        n0 = tx_n; r0 = rsp_cnt;
        do_req(1'b1, 1'b0, 14'h02A5, 32'h55AA00FF, acc);
        wait_rsp(r0, 100);
        expect_tx("post", n0, 6, 48'h82A5_55AA_00FF);
        chk_val("post_rdata", 32'(rsp_data_q), 32'd0);

        repeat (3) tick();
        chk_val("rsp_total", 32'(rsp_cnt), 32'd6);
        chk_val("fifo_violations", 32'(viol), 32'd0);
        chk_val("rsp_pulse_width", 32'(dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
